// File: rtl/line_pkg.sv
// line_pkg: shared coordinate, vertex and state types for the line sequencer
package line_pkg;
  typedef logic signed [10:0] coord_t;
  typedef struct packed {
    coord_t x;
    coord_t y;
  } vertex_t;
  typedef enum logic [2:0] {IDLE, SETUP, DRAW, NEXT, FINISH} seq_state_t;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
endpackage

// File: rtl/vertex_buffer.sv
// vertex_buffer: vertex register file with one synchronous write port and two asynchronous read ports
module vertex_buffer import line_pkg::*; #(
  parameter int MAX_VERTS = 16,
  parameter int IW = $clog2(MAX_VERTS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] wa,
  input  vertex_t       wd,
  input  logic [IW-1:0] ra,
  input  logic [IW-1:0] rb,
  output vertex_t       qa,
  output vertex_t       qb
);
  vertex_t mem [MAX_VERTS];
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  assign qa = mem[ra];
  assign qb = mem[rb];
endmodule

// File: rtl/line_sequencer.sv
// line_sequencer: buffers polyline vertices and feeds segments to the line drawer; LINE_SEQ_CLOSE_LOOP_EN adds the closing segment
module line_sequencer import line_pkg::*; #(
  parameter int MAX_VERTS = 16,
  parameter int SETUP_CYCLES = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           vtx_valid,
  output logic                           vtx_ready,
  input  logic signed [10:0]             vtx_x,
  input  logic signed [10:0]             vtx_y,
  input  logic                           vtx_last,
  input  logic                           abort,
  output logic signed [10:0]             x0,
  output logic signed [10:0]             y0,
  output logic signed [10:0]             x1,
  output logic signed [10:0]             y1,
  output logic                           start,
  input  logic                           done,
  output logic                           busy,
  output logic [$clog2(MAX_VERTS+1)-1:0] seg_count,
  output logic                           frame_done
);
  localparam int IW = $clog2(MAX_VERTS);
  localparam int NW = $clog2(MAX_VERTS+1);
  localparam int CW = $clog2(SETUP_CYCLES+1);
  seq_state_t state;
  logic [IW-1:0] wr_ptr, rd_idx, ra, rb;
  logic [NW-1:0] n, segs, rb_w;
  logic [CW-1:0] cnt;
  vertex_t vin, qa, qb, p0, p1;
  logic accept, full;
  assign vin = '{x: vtx_x, y: vtx_y};
  assign accept = vtx_valid && vtx_ready && !abort;
  assign full = wr_ptr == IW'(MAX_VERTS-1);
  assign x0 = p0.x;
  assign y0 = p0.y;
  assign x1 = p1.x;
  assign y1 = p1.y;
  always_comb begin
    ra = state == NEXT ? rd_idx + 1'b1 : '0;
    rb_w = NW'(ra) + 1'b1;
    rb = (state == NEXT && rb_w >= n) ? '0 : IW'(rb_w);
`ifdef LINE_SEQ_CLOSE_LOOP_EN
    segs = n >= NW'(3) ? n : NW'(1);
`else
    segs = n == NW'(1) ? NW'(1) : n - 1'b1;
`endif
  end
  vertex_buffer #(.MAX_VERTS(MAX_VERTS)) u_buf (
    .clk(clk),
    .we(accept),
    .wa(wr_ptr),
    .wd(vin),
    .ra(ra),
    .rb(rb),
    .qa(qa),
    .qb(qb)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      vtx_ready <= 1'b1;
      start <= 1'b0;
      busy <= 1'b0;
      frame_done <= 1'b0;
      seg_count <= '0;
      wr_ptr <= '0;
      rd_idx <= '0;
      n <= '0;
      cnt <= '0;
      p0 <= '0;
      p1 <= '0;
    end else if (abort && (state == SETUP || state == DRAW || state == NEXT)) begin
      state <= IDLE;
      vtx_ready <= 1'b1;
      start <= 1'b0;
      busy <= 1'b0;
      frame_done <= 1'b0;
      wr_ptr <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE:
          if (abort) wr_ptr <= '0;
          else if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
            seg_count <= '0;
            if (vtx_last || full) begin
              state <= SETUP;
              vtx_ready <= 1'b0;
              busy <= 1'b1;
              n <= NW'(wr_ptr) + 1'b1;
              rd_idx <= '0;
              cnt <= '0;
              p0 <= wr_ptr == '0 ? vin : qa;
              p1 <= wr_ptr <= IW'(1) ? vin : qb;
            end
          end
        SETUP: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(SETUP_CYCLES-1)) begin
            state <= DRAW;
            start <= 1'b1;
          end
        end
        DRAW:
          if (done) begin
            state <= NEXT;
            start <= 1'b0;
          end
        NEXT: begin
          seg_count <= seg_count + 1'b1;
          rd_idx <= rd_idx + 1'b1;
          cnt <= '0;
          p0 <= qa;
          p1 <= qb;
          if (NW'(rd_idx) + 1'b1 < segs) state <= SETUP;
          else begin
            state <= FINISH;
            frame_done <= 1'b1;
          end
        end
        FINISH: begin
          state <= IDLE;
          wr_ptr <= '0;
          vtx_ready <= 1'b1;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/line_sequencer.md
Name: line_sequencer

Overview:
- Upstream feeder for the line-drawing stage.
- Accepts a stream of polyline vertices over a valid/ready handshake and stores them in an internal vertex buffer.
- Once the vertex flagged last is accepted, issues consecutive segments (v0->v1, v1->v2, ...) to the line drawer on its x0/y0/x1/y1/start/done interface, one at a time.
- Reports completion back to the top-level control.

Parameters:
- MAX_VERTS, 16, vertex buffer depth; minimum 2.
- SETUP_CYCLES, 2, cycles that start is held low per segment so the drawer reloads endpoints and clears done; minimum 1.

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high reset
- vtx_valid  in  1  vertex present on vtx_x/vtx_y
- vtx_ready  out  1  sequencer can accept a vertex
- vtx_x  in  11 signed  vertex x coordinate
- vtx_y  in  11 signed  vertex y coordinate
- vtx_last  in  1  accompanying vertex is final of polyline
- abort  in  1  cancel current polyline
- x0, y0, x1, y1  out  11 signed each  segment endpoints to drawer
- start  out  1  drawer enable; low = drawer reload
- done  in  1  drawer finished current segment
- busy  out  1  high in any state except IDLE
- seg_count  out  $clog2(MAX_VERTS+1)  segments completed in current polyline
- frame_done  out  1  one-cycle pulse when polyline completes

Behaviour:
- Reset: state IDLE, vtx_ready=1, start=0, busy=0, frame_done=0, seg_count=0, x0=y0=x1=y1=0, write pointer=0.
- States: IDLE, SETUP, DRAW, NEXT, FINISH.
- IDLE:
  - vtx_ready=1.
  - Vertex accepted on vtx_valid && vtx_ready; written at wr_ptr; wr_ptr increments.
  - Transition to SETUP next cycle if vtx_last=1 or wr_ptr==MAX_VERTS-1 (full: forced last).
  - Store count n=wr_ptr+1 and set rd_idx=0.
- SETUP:
  - start=0.
  - Endpoints driven from buffer: (x0,y0)=v[rd_idx]; (x1,y1)=v[rd_idx+1], or v[0] when n==1 (single pixel).
  - Endpoints are registered, stable from the first SETUP cycle until leaving DRAW.
  - After SETUP_CYCLES cycles, go to DRAW.
- DRAW:
  - start=1.
  - On done=1, go to NEXT. done is only sampled in DRAW.
- NEXT:
  - start=0; seg_count+1; rd_idx+1.
  - If rd_idx+1 < n-1, go to SETUP; else go to FINISH.
  - When n==1, go to FINISH after one segment.
- FINISH:
  - frame_done=1 for one cycle; start=0; wr_ptr cleared; go to IDLE.
  - seg_count holds its value until the next accepted vertex, which clears it.
- vtx_ready=0 in every state but IDLE; vertices offered then are not consumed.
- abort in SETUP/DRAW/NEXT:
  - Next cycle: state IDLE, start=0, wr_ptr=0.
  - No frame_done pulse; seg_count keeps its partial value.
  - abort in IDLE clears wr_ptr (discards partial load).
- abort and done in the same DRAW cycle: abort wins.
- reset mid-operation: identical to power-on reset; buffer contents are don't-care.
- Coordinates pass through unmodified (no clipping, no width change).
- Latency: first start rise occurs SETUP_CYCLES+1 cycles after last vertex acceptance.
- Inter-segment gap: 1 (NEXT) + SETUP_CYCLES cycles with start low.

Optional Feature:
- Macro: LINE_SEQ_CLOSE_LOOP_EN.
- Defined:
  - After the final open segment, if n>=3, one extra segment v[n-1]->v[0] is drawn before FINISH.
  - seg_count ends at n.
- Undefined:
  - Open polyline only; seg_count ends at n-1 (1 when n==1).

Decomposition:
- Package line_pkg:
  - typedef coord_t (logic signed [10:0]).
  - typedef struct vertex_t {coord_t x, y}.
  - seq_state_t enum.
  - Screen constants SCREEN_W=640, SCREEN_H=480.
- Sub-module vertex_buffer:
  - MAX_VERTS x vertex_t register file.
  - One synchronous write port, two asynchronous read ports (rd_idx, rd_idx+1/wrap).
  - Instantiated once.

Test Plan:
- Load (0,0),(10,10),(20,0) with last on third, drawer model asserts done 5 cycles after start rise -> two segments: (0,0)->(10,10) then (10,10)->(20,0); start low exactly SETUP_CYCLES+1 cycles between them; frame_done pulse once; seg_count=2.
- Single vertex (100,100) with last -> one segment (100,100)->(100,100); seg_count=1; frame_done.
- Load 16 vertices with MAX_VERTS=16, never asserting last -> 16th vertex forced last; 15 segments drawn; vtx_ready=0 throughout drawing.
- abort asserted in DRAW of second segment of 4-vertex polyline -> start=0 and IDLE next cycle; no frame_done; seg_count=1; vtx_ready=1.
- Reset during DRAW -> all outputs return to reset values the next cycle; subsequent 2-vertex load (5,5),(5,105) draws one segment correctly.
- With LINE_SEQ_CLOSE_LOOP_EN, square (0,0),(50,0),(50,50),(0,50) -> four segments, last (0,50)->(0,0); seg_count=4.
